// File: rtl/gray_ptr_sync_if.sv
// Bus bundle for gray_ptr_sync: asynchronous pointer in, synchronised view and
// integrity-monitor status out. The slave side is the synchroniser itself.
interface gray_ptr_sync_if #(
    parameter int BUS_WIDTH = 4,
    parameter int ERR_CNT_W = 8
);
    logic [BUS_WIDTH-1:0] async;
    logic                 err_clr;
    logic [BUS_WIDTH-1:0] sync;
    logic [BUS_WIDTH-1:0] sync_bin;
    logic [BUS_WIDTH-1:0] sync_rise;
    logic [BUS_WIDTH-1:0] sync_fall;
    logic                 sync_chg;
    logic                 gray_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output async, err_clr,
        input  sync, sync_bin, sync_rise, sync_fall, sync_chg, gray_err, err_cnt
    );

    modport slave (
        input  async, err_clr,
        output sync, sync_bin, sync_rise, sync_fall, sync_chg, gray_err, err_cnt
    );
endinterface

// File: rtl/gray_ptr_sync.sv
// Multi-flop CDC synchroniser bank for a Gray-coded pointer, with Gray-to-binary
// conversion, per-bit edge pulses and a multi-bit-change integrity monitor.
module gray_ptr_sync #(
    parameter int BUS_WIDTH  = 4,
    parameter int NUM_STAGES = 2,
    parameter bit GRAY_CHECK = 1'b1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    gray_ptr_sync_if.slave   bus
);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("gray_ptr_sync: NUM_STAGES must be at least 2");
    end
    if (BUS_WIDTH < 1 || BUS_WIDTH > 32) begin : g_bad_width
        $error("gray_ptr_sync: BUS_WIDTH must be in 1..32");
    end

    // stages[0] is the capture flop; stages[NUM_STAGES-1] is the settled value.
    logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] stages;
    logic [BUS_WIDTH-1:0]                 sync;
    logic [BUS_WIDTH-1:0]                 prev;
    logic [BUS_WIDTH-1:0]                 diff;
    logic [BUS_WIDTH-1:0]                 bin;
    logic                                 multi_bit;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples the pre-edge value of its neighbour; blocking here would
    // collapse the whole chain into one stage in simulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stages <= '0;
            prev   <= '0;
        end else begin
            stages <= {stages[NUM_STAGES-2:0], bus.async};
            prev   <= sync;
        end
    end

    assign sync      = stages[NUM_STAGES-1];
    assign diff      = sync ^ prev;
    // Clearing the lowest set bit leaves something only if two or more bits flipped.
    assign multi_bit = |(diff & (diff - 1'b1));

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        bin = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            bin[i] = ^(sync >> i);
        end
    end

    assign bus.sync      = sync;
    assign bus.sync_bin  = bin;
    assign bus.sync_rise = sync & ~prev;
    assign bus.sync_fall = ~sync & prev;
    assign bus.sync_chg  = |diff;

    if (GRAY_CHECK) begin : g_mon
        logic                 gray_err_q;
        logic [ERR_CNT_W-1:0] err_cnt_q;

        // A violation coinciding with err_clr clears first, then counts itself.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                gray_err_q <= 1'b0;
                err_cnt_q  <= '0;
            end else if (multi_bit) begin
                gray_err_q <= 1'b1;
                if (bus.err_clr) begin
                    err_cnt_q <= ERR_CNT_W'(1);
                end else if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end else if (bus.err_clr) begin
                gray_err_q <= 1'b0;
                err_cnt_q  <= '0;
            end
        end

        assign bus.gray_err = gray_err_q;
        assign bus.err_cnt  = err_cnt_q;
    end else begin : g_no_mon
        assign bus.gray_err = 1'b0;
        assign bus.err_cnt  = '0;
    end

endmodule
